// File: rtl/sap_host_router.sv
// Host-to-slave router: decodes one host command stream into N_SLV address windows,
// broadcasts the registered command, tracks one outstanding read and reports misses/timeouts.
module sap_host_router #(
    parameter int                      N_SLV    = 2,
    parameter int                      AW       = 32,
    parameter int                      DW       = 32,
    parameter logic [N_SLV*AW-1:0]     BASE     = {32'hb000_0000, 32'ha000_0000},
    parameter logic [N_SLV*AW-1:0]     SIZE     = {32'h1000_0000, 32'h1000_0000},
    parameter int                      TIMEOUT  = 16,
    parameter logic [DW-1:0]           ERR_DATA = 32'hdead_beef
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                host_cmd_vld,
    output logic                host_cmd_rdy,
    input  logic [AW-1:0]       host_addr,
    input  logic [DW-1:0]       host_data_w,
    input  logic                host_rw,
    output logic [DW-1:0]       host_data_r,
    output logic                host_rd_vld,
    output logic                host_rd_err,
    output logic [N_SLV-1:0]    slv_cmd_vld,
    output logic [AW-1:0]       slv_addr,
    output logic [DW-1:0]       slv_data_w,
    output logic                slv_rw,
    input  logic [N_SLV*DW-1:0] slv_data_r,
    input  logic [N_SLV-1:0]    slv_rd_vld,
    output logic [7:0]          err_cnt
);

    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     sel_reg;
    logic [TW-1:0]     timer_reg;

    logic [N_SLV-1:0]  hit;
    logic [N_SLV-1:0]  hit_oh;
    logic [SW-1:0]     hit_idx;
    logic              any_hit;
    logic              accept;
    logic              sel_rd_vld;
    logic [DW-1:0]     sel_data;

    logic              err_inc;
    logic              rsp_load;
    logic              rsp_err;
    logic              rd_start;

    // Unsigned offset compare also rejects addresses below the base via wrap-around.
    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_dec
            logic [AW-1:0] offset;
            assign offset  = host_addr - BASE[gi*AW +: AW];
            assign hit[gi] = (offset < SIZE[gi*AW +: AW]);
        end
    endgenerate

    always_comb begin
        hit_oh  = '0;
        hit_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_idx   = SW'(i);
            end
        end
    end

    assign any_hit      = |hit;
    assign host_cmd_rdy = (state_reg == IDLE);
    assign accept       = host_cmd_vld & host_cmd_rdy;
    assign sel_rd_vld   = slv_rd_vld[sel_reg];
    assign sel_data     = slv_data_r[sel_reg*DW +: DW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_inc    = 1'b0;
        rsp_load   = 1'b0;
        rsp_err    = 1'b0;
        rd_start   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    err_inc = ~any_hit;
                    if (host_rw) begin
                        if (any_hit) begin
                            rd_start   = 1'b1;
                            state_next = RD_WAIT;
                        end else begin
                            state_next = RD_ERR;
                        end
                    end
                end
            end
            RD_WAIT: begin
                // A response arriving in the timeout cycle takes priority over the error.
                if (sel_rd_vld) begin
                    rsp_load   = 1'b1;
                    state_next = IDLE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    rsp_load   = 1'b1;
                    rsp_err    = 1'b1;
                    err_inc    = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_ERR: begin
                rsp_load   = 1'b1;
                rsp_err    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slv_cmd_vld <= '0;
            slv_addr    <= '0;
            slv_data_w  <= '0;
            slv_rw      <= 1'b0;
            sel_reg     <= '0;
            timer_reg   <= '0;
            host_rd_vld <= 1'b0;
            host_rd_err <= 1'b0;
            host_data_r <= '0;
            err_cnt     <= '0;
        end else begin
            slv_cmd_vld <= (accept && any_hit) ? hit_oh : '0;
            if (accept) begin
                slv_addr   <= host_addr;
                slv_data_w <= host_data_w;
                slv_rw     <= host_rw;
            end
            if (rd_start) begin
                sel_reg <= hit_idx;
            end
            timer_reg   <= (state_reg == RD_WAIT) ? timer_reg + 1'b1 : '0;
            host_rd_vld <= rsp_load;
            if (rsp_load) begin
                host_rd_err <= rsp_err;
                host_data_r <= rsp_err ? ERR_DATA : sel_data;
            end
            if (err_inc && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
